bit_count_engine: RTL and testbench

Parametrised bit-counting engine, successor to the fixed 8-bit ones counter on the DE1_SoC board top. Captures a WIDTH-bit operand on a level start. Scans it LANE bits per clock in one of four modes: count ones, count zeros, trailing zeros or leading zeros. Stops early once no further bits can change the result, then holds the count with done until start is released. The board top drives it from SW, KEY and the divided clock, and shows count on the HEX decoders.

---
 rtl/bit_count_pkg.sv | 7 +
 rtl/bit_count_lane.sv | 30 +++
 rtl/bit_count_engine.sv | 106 ++++++++++
 tb/tb_bit_count_engine.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_count_pkg.sv
// rtl/bit_count_pkg.sv - shared types for the bit counting engine
package bit_count_pkg;

  typedef enum logic [1:0] {M_ONES, M_ZEROS, M_TZ, M_LZ} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

endpackage

// File: rtl/bit_count_lane.sv
// rtl/bit_count_lane.sv - combinational popcount / trailing-zero count of one lane
module bit_count_lane #(
  parameter int LANE = 1,
  localparam int LW  = $clog2(LANE + 1)
) (
  input  logic [LANE-1:0] lane,
  output logic [LW-1:0]   pop,
  output logic [LW-1:0]   tz,
  output logic            any_one
);

  logic seen;

  always_comb begin
    pop  = '0;
    tz   = '0;
    seen = 1'b0;
    for (int i = 0; i < LANE; i++) begin
      if (lane[i]) begin
        pop  = pop + LW'(1);
        seen = 1'b1;
      end else if (!seen) begin
        tz = tz + LW'(1);
      end
    end
  end

  assign any_one = |lane;

endmodule

// File: rtl/bit_count_engine.sv
// rtl/bit_count_engine.sv - multi-mode bit counter scanning LANE bits per clock
// with early exit; LZ is handled as TZ on the bit-reversed operand.
module bit_count_engine
  import bit_count_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANE  = 1,
  localparam int CW    = $clog2(WIDTH + 1),
  localparam int BEATS = WIDTH / LANE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW = $clog2(LANE + 1);

  state_t           ps;
  mode_t            mode_q;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] rest;
  logic [WIDTH-1:0] load_val;
  logic [BW-1:0]    beat;
  logic [LW-1:0]    lane_pop;
  logic [LW-1:0]    lane_tz;
  logic [LW-1:0]    add_v;
  logic             lane_any;
  logic             pop_mode;
  logic             finish;

  bit_count_lane #(.LANE(LANE)) u_lane (
    .lane    (sreg[LANE-1:0]),
    .pop     (lane_pop),
    .tz      (lane_tz),
    .any_one (lane_any)
  );

  always_comb begin
    load_val = in_data;
    case (mode_t'(mode))
      M_ZEROS: load_val = ~in_data;
      M_LZ: begin
        for (int i = 0; i < WIDTH; i++) load_val[i] = in_data[WIDTH-1-i];
      end
      default: load_val = in_data;
    endcase
  end

  assign rest     = sreg >> LANE;
  assign pop_mode = (mode_q == M_ONES) || (mode_q == M_ZEROS);
  assign add_v    = pop_mode ? lane_pop : lane_tz;
  // Stop as soon as the remaining bits can no longer change the count.
  assign finish   = (pop_mode && (rest == '0)) ||
                    (!pop_mode && lane_any) ||
                    (beat == BW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      ps     <= S_IDLE;
      count  <= '0;
      sreg   <= '0;
      beat   <= '0;
      mode_q <= M_ONES;
    end else begin
      case (ps)
        S_IDLE: begin
          count <= '0;
          beat  <= '0;
          if (start) begin
            sreg   <= load_val;
            mode_q <= mode_t'(mode);
            ps     <= S_RUN;
          end
        end
        S_RUN: begin
          if (!start) begin
            count <= '0;
            ps    <= S_IDLE;
          end else begin
            count <= count + CW'(add_v);
            sreg  <= rest;
            beat  <= beat + BW'(1);
            if (finish) ps <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start) begin
            count <= '0;
            ps    <= S_IDLE;
          end
        end
        default: ps <= S_IDLE;
      endcase
    end
  end

  assign busy = (ps == S_RUN);
  assign done = (ps == S_DONE);

endmodule

// File: tb/tb_bit_count_engine.sv
// tb/tb_bit_count_engine.sv - randomized and directed checks of two engine
// instances (LANE=1, LANE=2) against a result/beat-count model.
module tb_bit_count_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s [2];
  logic [1:0] mode_s  [2];
  logic [7:0] data_s  [2];
  logic [3:0] count_s [2];
  logic       busy_s  [2];
  logic       done_s  [2];

  int tests = 0;
  int fails = 0;

  int m_ph  [2] = '{0, 0};
  int m_rem [2] = '{0, 0};
  int m_res [2] = '{0, 0};

  always #5 clk = ~clk;

  bit_count_engine #(.WIDTH(8), .LANE(1)) dut_l1 (
    .clk(clk), .reset(reset), .start(start_s[0]), .mode(mode_s[0]),
    .in_data(data_s[0]), .count(count_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  bit_count_engine #(.WIDTH(8), .LANE(2)) dut_l2 (
    .clk(clk), .reset(reset), .start(start_s[1]), .mode(mode_s[1]),
    .in_data(data_s[1]), .count(count_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  function automatic int lane_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int ref_result(input int m, input logic [7:0] v);
    case (m)
      0: return $countones(v);
      1: return 8 - $countones(v);
      2: begin
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
      end
      default: begin
        for (int i = 7; i >= 0; i--) if (v[i]) return 7 - i;
        return 8;
      end
    endcase
  endfunction

  function automatic int ref_beats(input int m, input logic [7:0] v, input int lane);
    logic [7:0] t;
    int z;
    if (m < 2) begin
      t = (m == 1) ? ~v : v;
      if (t == 8'h00) return 1;
      for (int i = 7; i >= 0; i--) if (t[i]) return i / lane + 1;
      return 1;
    end
    z = ref_result(m, v);
    return (z == 8) ? 8 / lane : z / lane + 1;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_ph[d] <= 0;
      end else begin
        case (m_ph[d])
          0: if (start_s[d]) begin
            m_res[d] <= ref_result(int'(mode_s[d]), data_s[d]);
            m_rem[d] <= ref_beats(int'(mode_s[d]), data_s[d], lane_of(d));
            m_ph[d]  <= 1;
          end
          1: if (!start_s[d]) m_ph[d] <= 0;
             else begin
               m_rem[d] <= m_rem[d] - 1;
               if (m_rem[d] == 1) m_ph[d] <= 2;
             end
          default: if (!start_s[d]) m_ph[d] <= 0;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy[%0d]", d), 32'(busy_s[d]), (m_ph[d] == 1) ? 1 : 0);
      chk($sformatf("done[%0d]", d), 32'(done_s[d]), (m_ph[d] == 2) ? 1 : 0);
      if (m_ph[d] == 0) chk($sformatf("idle_count[%0d]", d), 32'(count_s[d]), 0);
      if (m_ph[d] == 2) chk($sformatf("done_count[%0d]", d), 32'(count_s[d]), 32'(m_res[d]));
    end
  endtask

  task automatic run_lit(input int d, input int m, input logic [7:0] v,
                         input int lit_count, input int lit_k, input bit swap);
    int nb;
    bit seen;
    chk("model_result", 32'(ref_result(m, v)), 32'(lit_count));
    chk("model_beats", 32'(ref_beats(m, v, lane_of(d))), 32'(lit_k));
    mode_s[d]  = 2'(m);
    data_s[d]  = v;
    start_s[d] = 1'b1;
    nb = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (swap) begin
        data_s[d] = 8'hFF;
        mode_s[d] = 2'd3;
      end
      if (busy_s[d]) nb++;
      if (done_s[d]) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 1);
    chk("lit_count", 32'(count_s[d]), 32'(lit_count));
    chk("lit_k", 32'(nb), 32'(lit_k));
    tick();
    chk("held_count", 32'(count_s[d]), 32'(lit_count));
    start_s[d] = 1'b0;
    tick();
    chk("released_done", 32'(done_s[d]), 0);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      mode_s[d]  = 2'd0;
      data_s[d]  = 8'h00;
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_count0", 32'(count_s[0]), 0);

    run_lit(0, 0, 8'h03, 2, 2, 1'b0);
    run_lit(1, 0, 8'hFF, 8, 4, 1'b0);
    run_lit(1, 0, 8'h00, 0, 1, 1'b0);
    run_lit(0, 1, 8'h00, 8, 8, 1'b0);
    run_lit(0, 2, 8'h08, 3, 4, 1'b0);
    run_lit(0, 3, 8'h01, 7, 8, 1'b0);
    run_lit(0, 3, 8'h00, 8, 8, 1'b0);
    run_lit(1, 3, 8'h00, 8, 4, 1'b0);
    run_lit(0, 0, 8'h07, 3, 3, 1'b1);

    // abort at beat 2 of a long run
    mode_s[0] = 2'd0;
    data_s[0] = 8'hF0;
    start_s[0] = 1'b1;
    tick();
    tick();
    start_s[0] = 1'b0;
    tick();
    chk("abort_count", 32'(count_s[0]), 0);
    chk("abort_busy", 32'(busy_s[0]), 0);
    run_lit(0, 0, 8'h07, 3, 3, 1'b0);

    // reset mid-run on both instances
    for (int d = 0; d < 2; d++) begin
      mode_s[d] = 2'd0;
      data_s[d] = 8'hF0;
      start_s[d] = 1'b1;
    end
    tick();
    tick();
    reset = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_mid_count", 32'(count_s[1]), 0);
    chk("rst_mid_busy", 32'(busy_s[0]), 0);
    tick();
    run_lit(1, 2, 8'h40, 6, 4, 1'b0);

    for (int n = 0; n < 80; n++) begin
      int d;
      int hold;
      d = int'($urandom_range(0, 1));
      mode_s[d] = 2'($urandom_range(0, 3));
      data_s[d] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      start_s[d] = 1'b1;
      hold = int'($urandom_range(1, 12));
      for (int c = 0; c < hold; c++) begin
        tick();
        if ($urandom_range(0, 1) == 1) begin
          data_s[d] = 8'($urandom);
          mode_s[d] = 2'($urandom_range(0, 3));
        end
      end
      start_s[d] = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
